// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_SKIP    = 2'b01,
    STAT_ILLEGAL = 2'b10
  } status_t;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  localparam logic [3:0] OP_MAX  = 4'd5;
  localparam logic [2:0] SRC_MAX = 3'd3;

endpackage

// File: rtl/alu_cond_eval.sv
// Condition-code evaluation against the architectural {N,Z,C,V} flags.
module alu_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLG_Z];
      COND_NE: pass = !flags[FLG_Z];
      COND_CS: pass = flags[FLG_C];
      COND_CC: pass = !flags[FLG_C];
      COND_MI: pass = flags[FLG_N];
      COND_PL: pass = !flags[FLG_N];
      COND_VS: pass = flags[FLG_V];
      COND_VC: pass = !flags[FLG_V];
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-requester round-robin arbiter and sequencer for the shared simple_ALU.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_r1,
  input  logic [1:0][31:0]      req_r2,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0][2:0]       req_src,
  input  logic [1:0][3:0]       req_cond,
  input  logic [1:0]            req_s,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [31:0]           alu_r1,
  output logic [31:0]           alu_r2,
  output logic [3:0]            alu_op,
  output logic [2:0]            alu_src,
  output logic [3:0]            alu_cond,
  output logic                  alu_s,
  output logic [3:0]            alu_flags,
  input  logic [32:0]           alu_out,
  input  logic [3:0]            alu_flg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [32:0]           rsp_result,
  output logic [1:0]            rsp_status,
  output logic [3:0]            flags_q
);

  state_t      state;
  status_t     pend_status;
  logic        ptr;
  logic [3:0]  cnt;
  logic [1:0]  grant;
  logic        gi;
  logic        cond_pass;
  logic        legal;

  always_comb begin
    grant = '0;
    if (state == ST_IDLE && !rst) begin
      if (req_valid == 2'b11) grant[ptr] = 1'b1;
      else                    grant      = req_valid;
    end
  end

  assign req_ready = grant;
  assign gi        = grant[1];
  assign legal     = (req_op[gi] <= OP_MAX) && (req_src[gi] <= SRC_MAX);
  assign alu_cond  = '0;
  assign alu_flags = flags_q;

  alu_cond_eval u_cond (
    .cond  (req_cond[gi]),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend_status <= STAT_OK;
      ptr         <= 1'b0;
      cnt         <= '0;
      flags_q     <= '0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      alu_op      <= '0;
      alu_src     <= '0;
      alu_s       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_tag     <= '0;
      rsp_result  <= '0;
      rsp_status  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            ptr     <= ~gi;
            rsp_id  <= gi;
            rsp_tag <= req_tag[gi];
            // SKIP/ILLEGAL take one pass through CAPTURE without sampling,
            // so their response rises one edge after accept.
            if (!legal) begin
              pend_status <= STAT_ILLEGAL;
              state       <= ST_CAPTURE;
            end else if (!cond_pass) begin
              pend_status <= STAT_SKIP;
              state       <= ST_CAPTURE;
            end else begin
              pend_status <= STAT_OK;
              alu_r1      <= req_r1[gi];
              alu_r2      <= req_r2[gi];
              alu_op      <= req_op[gi];
              alu_src     <= req_src[gi];
              alu_s       <= req_s[gi];
              cnt         <= 4'(ALU_WAIT - 1);
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - 4'd1;
        end
        ST_CAPTURE: begin
          rsp_status <= pend_status;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
          if (pend_status == STAT_OK) begin
            rsp_result <= alu_out;
            if (alu_s) flags_q <= alu_flg;
          end else begin
            rsp_result <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: transaction-level model plus directed pins.
module tb_alu_issue_ctrl;

  localparam int TAG_W = 4;
  localparam int W     = 1;

  logic                  clk;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_r1;
  logic [1:0][31:0]      req_r2;
  logic [1:0][3:0]       req_op;
  logic [1:0][2:0]       req_src;
  logic [1:0][3:0]       req_cond;
  logic [1:0]            req_s;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [31:0]           alu_r1, alu_r2;
  logic [3:0]            alu_op;
  logic [2:0]            alu_src;
  logic [3:0]            alu_cond;
  logic                  alu_s;
  logic [3:0]            alu_flags;
  logic [32:0]           alu_out;
  logic [3:0]            alu_flg;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic [32:0]           rsp_result;
  logic [1:0]            rsp_status;
  logic [3:0]            flags_q;

  alu_issue_ctrl #(.TAG_W(TAG_W), .ALU_WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_r1(req_r1), .req_r2(req_r2), .req_op(req_op), .req_src(req_src),
    .req_cond(req_cond), .req_s(req_s), .req_tag(req_tag),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op), .alu_src(alu_src),
    .alu_cond(alu_cond), .alu_s(alu_s), .alu_flags(alu_flags),
    .alu_out(alu_out), .alu_flg(alu_flg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_status(rsp_status),
    .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stand-in ALU: op 0 AND,1 OR,2 SUB,3 XOR,4 ADD,5 MOV; src shifts operand 2.
  function automatic logic [36:0] fake_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic [2:0] src);
    logic [31:0] o2;
    logic [32:0] res;
    logic        v;
    case (src)
      3'd0:    o2 = b;
      3'd1:    o2 = b << 1;
      3'd2:    o2 = b >> 1;
      default: o2 = {b[0], b[31:1]};
    endcase
    case (op)
      4'd0:    res = {1'b0, a & o2};
      4'd1:    res = {1'b0, a | o2};
      4'd2:    res = {1'b0, a} - {1'b0, o2};
      4'd3:    res = {1'b0, a ^ o2};
      4'd4:    res = {1'b0, a} + {1'b0, o2};
      default: res = {1'b0, o2};
    endcase
    if (op == 4'd4)      v = (a[31] == o2[31]) && (res[31] != a[31]);
    else if (op == 4'd2) v = (a[31] != o2[31]) && (res[31] != a[31]);
    else                 v = 1'b0;
    return {res[31], res[31:0] == 32'd0, res[32], v, res};
  endfunction

  always_comb {alu_flg, alu_out} = fake_alu(alu_r1, alu_r2, alu_op, alu_src);

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0: return 1'b1;
      4'd1: return f[2];
      4'd2: return !f[2];
      4'd3: return f[1];
      4'd4: return !f[1];
      4'd5: return f[3];
      4'd6: return !f[3];
      4'd7: return f[0];
      4'd8: return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int grant_of(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 1 : 0;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Transaction model: busy countdown until the response appears.
  bit          m_idle = 1'b1;
  int          m_wait = 0;
  logic        m_ptr = 1'b0;
  logic [3:0]  m_flags = '0;
  bit          m_rv = 1'b0;
  logic        m_id = 1'b0;
  logic [3:0]  m_tag = '0;
  logic [32:0] m_res = '0;
  logic [1:0]  m_stat = '0;
  logic [1:0]  p_stat = '0;
  logic [31:0] m_ar1 = '0, m_ar2 = '0;
  logic [3:0]  m_aop = '0;
  logic [2:0]  m_asrc = '0;
  logic        m_as = 1'b0;

  task automatic model_step();
    int g;
    logic [36:0] fo;
    if (rst) begin
      m_idle = 1'b1; m_wait = 0; m_ptr = 1'b0; m_flags = '0; m_rv = 1'b0;
      m_id = 1'b0; m_tag = '0; m_res = '0; m_stat = '0;
      m_ar1 = '0; m_ar2 = '0; m_aop = '0; m_asrc = '0; m_as = 1'b0;
    end else if (m_rv) begin
      if (rsp_ready) begin
        m_rv = 1'b0;
        m_idle = 1'b1;
      end
    end else if (!m_idle) begin
      m_wait--;
      if (m_wait == 0) begin
        m_rv = 1'b1;
        m_stat = p_stat;
        if (p_stat == 2'b00) begin
          fo = fake_alu(m_ar1, m_ar2, m_aop, m_asrc);
          m_res = fo[32:0];
          if (m_as) m_flags = fo[36:33];
        end else begin
          m_res = '0;
        end
      end
    end else begin
      g = grant_of(req_valid, m_ptr);
      if (g >= 0) begin
        m_ptr = (g == 0);
        m_id = (g == 1);
        m_tag = req_tag[g];
        if (req_op[g] > 4'd5 || req_src[g] > 3'd3) p_stat = 2'b10;
        else if (!cond_true(req_cond[g], m_flags)) p_stat = 2'b01;
        else p_stat = 2'b00;
        if (p_stat == 2'b00) begin
          m_ar1 = req_r1[g]; m_ar2 = req_r2[g]; m_aop = req_op[g];
          m_asrc = req_src[g]; m_as = req_s[g];
          m_wait = W + 1;
        end else begin
          m_wait = 1;
        end
        m_idle = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [1:0] er;
      int g;
      er = '0;
      if (!rst && m_idle) begin
        g = grant_of(req_valid, m_ptr);
        if (g >= 0) er[g] = 1'b1;
      end
      chk("m_req_ready", 64'(req_ready), 64'(er));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
      chk("m_rsp_tag", 64'(rsp_tag), 64'(m_tag));
      chk("m_rsp_result", 64'(rsp_result), 64'(m_res));
      chk("m_rsp_status", 64'(rsp_status), 64'(m_stat));
      chk("m_flags_q", 64'(flags_q), 64'(m_flags));
      chk("m_alu_flags", 64'(alu_flags), 64'(m_flags));
      chk("m_alu_cond", 64'(alu_cond), 64'd0);
      chk("m_alu_r1", 64'(alu_r1), 64'(m_ar1));
      chk("m_alu_r2", 64'(alu_r2), 64'(m_ar2));
      chk("m_alu_ctl", 64'({alu_op, alu_src, alu_s}), 64'({m_aop, m_asrc, m_as}));
    end
  end

  task automatic set_req(input int idx, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [3:0] op, input logic [2:0] src, input logic [3:0] cond,
                         input logic s, input logic [3:0] tag);
    req_r1[idx] = r1; req_r2[idx] = r2; req_op[idx] = op; req_src[idx] = src;
    req_cond[idx] = cond; req_s[idx] = s; req_tag[idx] = tag;
  endtask

  // Presents one request, waits for its accept, then counts edges to rsp_valid.
  task automatic send(input int idx, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [3:0] op, input logic [2:0] src, input logic [3:0] cond,
                      input logic s, input logic [3:0] tag, output int lat);
    int t;
    @(posedge clk); #1;
    req_valid = '0;
    set_req(idx, r1, r2, op, src, cond, s, tag);
    req_valid[idx] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[idx] && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (t == 50) chk("accept_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 50);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int ids[$];
    int t;
    logic [31:0] keep_r1;
    logic [3:0]  keep_op;

    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_r1 = '0; req_r2 = '0; req_op = '0; req_src = '0;
    req_cond = '0; req_s = '0; req_tag = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_alu_r1", 64'(alu_r1), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;

    // ADD 5+7 from requester 0, then a held response
    send(0, 32'd5, 32'd7, 4'd4, 3'd0, 4'd0, 1'b1, 4'hA, lat);
    chk("add_latency", 64'(lat), 64'd2);
    chk("add_result", 64'(rsp_result), 64'd12);
    chk("add_status", 64'(rsp_status), 64'd0);
    chk("add_id", 64'(rsp_id), 64'd0);
    chk("add_tag", 64'(rsp_tag), 64'hA);
    chk("add_flags", 64'(flags_q), 64'd0);
    set_req(1, 32'd1, 32'd1, 4'd4, 3'd0, 4'd0, 1'b0, 4'h1);
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_result", 64'(rsp_result), 64'd12);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    handshake();
    #1;
    chk("post_hs_ready", 64'(req_ready), 64'b10);
    req_valid = '0;

    // SUB to zero sets Z, EQ passes, NE skips
    send(0, 32'd3, 32'd3, 4'd2, 3'd0, 4'd0, 1'b1, 4'h1, lat);
    chk("sub_latency", 64'(lat), 64'd2);
    chk("sub_result", 64'(rsp_result), 64'd0);
    chk("sub_flags", 64'(flags_q), 64'b0100);
    handshake();
    send(1, 32'd10, 32'd4, 4'd2, 3'd0, 4'd1, 1'b0, 4'h2, lat);
    chk("eq_status", 64'(rsp_status), 64'd0);
    chk("eq_result", 64'(rsp_result), 64'd6);
    chk("eq_flags", 64'(flags_q), 64'b0100);
    handshake();
    keep_r1 = alu_r1; keep_op = alu_op;
    send(0, 32'd99, 32'd1, 4'd4, 3'd0, 4'd2, 1'b1, 4'h3, lat);
    chk("ne_latency", 64'(lat), 64'd1);
    chk("ne_status", 64'(rsp_status), 64'd1);
    chk("ne_result", 64'(rsp_result), 64'd0);
    chk("ne_flags", 64'(flags_q), 64'b0100);
    chk("ne_alu_r1", 64'(alu_r1), 64'd10);
    chk("ne_alu_op", 64'(alu_op), 64'(keep_op));
    handshake();

    // Illegal op and illegal src
    send(1, 32'd1, 32'd1, 4'd6, 3'd0, 4'd0, 1'b1, 4'h4, lat);
    chk("ill_op_latency", 64'(lat), 64'd1);
    chk("ill_op_status", 64'(rsp_status), 64'd2);
    chk("ill_op_alu_r1", 64'(alu_r1), 64'(keep_r1));
    handshake();
    send(0, 32'd1, 32'd1, 4'd0, 3'd4, 4'd0, 1'b1, 4'h5, lat);
    chk("ill_src_status", 64'(rsp_status), 64'd2);
    chk("ill_src_flags", 64'(flags_q), 64'b0100);
    handshake();

    // Reset while the op is in ISSUE
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd2, 4'd4, 3'd0, 4'd0, 1'b1, 4'h6);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_flags", 64'(flags_q), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Both requesters always valid: alternating grants starting at 0
    set_req(0, 32'd2, 32'd3, 4'd4, 3'd0, 4'd0, 1'b0, 4'h7);
    set_req(1, 32'd4, 32'd5, 4'd1, 3'd1, 4'd0, 1'b0, 4'h8);
    req_valid = 2'b11;
    #1;
    chk("first_grant", 64'(req_ready), 64'b01);
    rsp_ready = 1'b1;
    t = 0;
    while (ids.size() < 4 && t < 100) begin
      @(posedge clk); #1;
      if (rsp_valid) ids.push_back(int'(rsp_id));
      t++;
    end
    chk("rr_count", 64'(ids.size()), 64'd4);
    if (ids.size() == 4) begin
      chk("rr_0", 64'(ids[0]), 64'd0);
      chk("rr_1", 64'(ids[1]), 64'd1);
      chk("rr_2", 64'(ids[2]), 64'd0);
      chk("rr_3", 64'(ids[3]), 64'd1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_r1[i]    = $urandom;
        req_r2[i]    = ($urandom_range(0, 3) == 0) ? req_r1[i] : $urandom;
        req_op[i]    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
        req_src[i]   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        req_cond[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        req_s[i]     = 1'($urandom_range(0, 1));
        req_tag[i]   = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    req_valid = '0; rst = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
